// File: rtl/cpu_control.sv
// cpu_control: multicycle RV32I control FSM sequencing fetch, decode, execute, memory and writeback.
// Defining CPU_CONTROL_PERF_EN adds the perf_cycles/perf_instret counter outputs.
module cpu_control #(
    parameter int MEM_TIMEOUT = 0
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [6:0]  opcode,
    input  logic [2:0]  funct3,
    input  logic [6:0]  funct7,
    input  logic        br_en,
    input  logic [1:0]  mem_addr_lo,
    input  logic        mem_resp,
    output logic        mem_read,
    output logic        mem_write,
    output logic [3:0]  mem_byte_enable,
    output logic        load_pc,
    output logic        load_ir,
    output logic        load_regfile,
    output logic        load_mar,
    output logic        load_mdr,
    output logic        load_data_out,
    output logic        pcmux_sel,
    output logic        alumux1_sel,
    output logic        marmux_sel,
    output logic        cmpmux_sel,
    output logic [1:0]  alumux2_sel,
    output logic [1:0]  alumux3_sel,
    output logic [2:0]  regfilemux_sel,
    output logic [2:0]  aluop,
    output logic [2:0]  cmpop,
    output logic [2:0]  ldop
`ifdef CPU_CONTROL_PERF_EN
    ,
    output logic [31:0] perf_cycles,
    output logic [31:0] perf_instret
`endif
);
    localparam logic [6:0] OP_LUI = 7'b0110111, OP_AUIPC = 7'b0010111, OP_JAL = 7'b1101111,
                           OP_JALR = 7'b1100111, OP_BR = 7'b1100011, OP_LOAD = 7'b0000011,
                           OP_STORE = 7'b0100011, OP_IMM = 7'b0010011, OP_REG = 7'b0110011;
    localparam logic [2:0] ALU_ADD = 3'b000, ALU_SRA = 3'b010, ALU_SUB = 3'b011, ALU_SRL = 3'b101;
    localparam logic [2:0] BR_BEQ = 3'b000, BR_BLT = 3'b100, BR_BLTU = 3'b110;
    localparam logic [2:0] F3_ADD = 3'b000, F3_SLT = 3'b010, F3_SLTU = 3'b011, F3_SR = 3'b101;
    localparam logic [2:0] F3_SB = 3'b000, F3_SH = 3'b001;
    localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT + 1) : 1;

    typedef enum logic [4:0] {
        S_FETCH1, S_FETCH2, S_FETCH3, S_DECODE,
        S_IMM, S_REG, S_LUI, S_AUIPC, S_BR, S_JAL, S_JALR,
        S_CALC_LD, S_LD1, S_LD2, S_CALC_ST, S_ST1, S_ST2, S_SKIP
    } state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] wait_cnt_q, wait_cnt_d;
    logic             drop_q, drop_d;
    logic             wait_st, req, resp_ok;
    logic             unused_funct7;

    assign unused_funct7 = ^{funct7[6], funct7[4:0]};
    assign wait_st = (state_q == S_FETCH2) || (state_q == S_LD1) || (state_q == S_ST1);
    assign req     = wait_st && !drop_q;
    assign resp_ok = req && mem_resp;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= S_FETCH1;
            wait_cnt_q <= '0;
            drop_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            wait_cnt_q <= wait_cnt_d;
            drop_q     <= drop_d;
        end
    end

    // Timeout: after MEM_TIMEOUT unanswered request cycles, release the request for one cycle.
    always_comb begin
        wait_cnt_d = '0;
        drop_d     = 1'b0;
        if (req && !mem_resp && (MEM_TIMEOUT > 0)) begin
            if (int'(wait_cnt_q) + 1 >= MEM_TIMEOUT) drop_d = 1'b1;
            else wait_cnt_d = wait_cnt_q + CNT_W'(1);
        end
    end

    always_comb begin
        state_d         = state_q;
        mem_read        = 1'b0;
        mem_write       = 1'b0;
        mem_byte_enable = 4'hF;
        load_pc         = 1'b0;
        load_ir         = 1'b0;
        load_regfile    = 1'b0;
        load_mar        = 1'b0;
        load_mdr        = 1'b0;
        load_data_out   = 1'b0;
        pcmux_sel       = 1'b0;
        alumux1_sel     = 1'b0;
        marmux_sel      = 1'b0;
        cmpmux_sel      = 1'b0;
        alumux2_sel     = 2'd0;
        alumux3_sel     = 2'd0;
        regfilemux_sel  = 3'd0;
        aluop           = ALU_ADD;
        cmpop           = BR_BEQ;
        ldop            = 3'd0;
        // Outputs stay at defaults while reset is held so nothing loads mid-reset.
        if (!rst) begin
            case (state_q)
                S_FETCH1: begin load_mar = 1'b1; state_d = S_FETCH2; end
                S_FETCH2: begin
                    mem_read = req;
                    load_mdr = req;
                    if (resp_ok) state_d = S_FETCH3;
                end
                S_FETCH3: begin load_ir = 1'b1; state_d = S_DECODE; end
                S_DECODE: begin
                    case (opcode)
                        OP_IMM:   state_d = S_IMM;
                        OP_REG:   state_d = S_REG;
                        OP_LUI:   state_d = S_LUI;
                        OP_AUIPC: state_d = S_AUIPC;
                        OP_BR:    state_d = S_BR;
                        OP_JAL:   state_d = S_JAL;
                        OP_JALR:  state_d = S_JALR;
                        OP_LOAD:  state_d = S_CALC_LD;
                        OP_STORE: state_d = S_CALC_ST;
                        default:  state_d = S_SKIP;
                    endcase
                end
                S_IMM: begin
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                    case (funct3)
                        F3_SLT:  begin cmpmux_sel = 1'b1; cmpop = BR_BLT;  regfilemux_sel = 3'd1; end
                        F3_SLTU: begin cmpmux_sel = 1'b1; cmpop = BR_BLTU; regfilemux_sel = 3'd1; end
                        F3_SR:   aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                        default: aluop = funct3;
                    endcase
                end
                S_REG: begin
                    alumux3_sel  = 2'd1;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                    case (funct3)
                        F3_ADD:  aluop = funct7[5] ? ALU_SUB : ALU_ADD;
                        F3_SLT:  begin cmpop = BR_BLT;  regfilemux_sel = 3'd1; end
                        F3_SLTU: begin cmpop = BR_BLTU; regfilemux_sel = 3'd1; end
                        F3_SR:   aluop = funct7[5] ? ALU_SRA : ALU_SRL;
                        default: aluop = funct3;
                    endcase
                end
                S_LUI: begin
                    regfilemux_sel = 3'd2;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_AUIPC: begin
                    alumux1_sel  = 1'b1;
                    alumux2_sel  = 2'd1;
                    load_regfile = 1'b1;
                    load_pc      = 1'b1;
                    state_d      = S_FETCH1;
                end
                S_BR: begin
                    cmpop       = funct3;
                    alumux1_sel = 1'b1;
                    alumux2_sel = 2'd2;
                    pcmux_sel   = br_en;
                    load_pc     = 1'b1;
                    state_d     = S_FETCH1;
                end
                S_JAL: begin
                    regfilemux_sel = 3'd4;
                    load_regfile   = 1'b1;
                    alumux1_sel    = 1'b1;
                    alumux3_sel    = 2'd2;
                    pcmux_sel      = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_JALR: begin
                    regfilemux_sel = 3'd4;
                    load_regfile   = 1'b1;
                    pcmux_sel      = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_CALC_LD: begin
                    marmux_sel = 1'b1;
                    load_mar   = 1'b1;
                    state_d    = S_LD1;
                end
                S_LD1: begin
                    mem_read = req;
                    load_mdr = req;
                    if (resp_ok) state_d = S_LD2;
                end
                S_LD2: begin
                    regfilemux_sel = 3'd3;
                    ldop           = funct3;
                    load_regfile   = 1'b1;
                    load_pc        = 1'b1;
                    state_d        = S_FETCH1;
                end
                S_CALC_ST: begin
                    alumux2_sel   = 2'd3;
                    marmux_sel    = 1'b1;
                    load_mar      = 1'b1;
                    load_data_out = 1'b1;
                    state_d       = S_ST1;
                end
                S_ST1: begin
                    mem_write = req;
                    case (funct3)
                        F3_SB:   mem_byte_enable = 4'(4'h1 << mem_addr_lo);
                        F3_SH:   mem_byte_enable = 4'(4'h3 << mem_addr_lo);
                        default: mem_byte_enable = 4'hF;
                    endcase
                    if (resp_ok) state_d = S_ST2;
                end
                S_ST2:   begin load_pc = 1'b1; state_d = S_FETCH1; end
                S_SKIP:  begin load_pc = 1'b1; state_d = S_FETCH1; end
                default: state_d = S_FETCH1;
            endcase
        end
    end

`ifdef CPU_CONTROL_PERF_EN
    logic [31:0] perf_cycles_q, perf_instret_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            perf_cycles_q  <= '0;
            perf_instret_q <= '0;
        end else begin
            perf_cycles_q <= perf_cycles_q + 32'd1;
            if (load_pc) perf_instret_q <= perf_instret_q + 32'd1;
        end
    end

    assign perf_cycles  = perf_cycles_q;
    assign perf_instret = perf_instret_q;
`endif

endmodule

// File: doc/cpu_control.md
Name: cpu_control

Overview:
- Multicycle FSM that sequences the RV32I datapath: fetch, decode, execute, memory access and writeback.
- Drives every datapath load enable, mux select and ALU/CMP op.
- Runs the memory read/write handshake.
- Sits beside the datapath inside the cpu top level; one instruction in flight.

Parameters:
- MEM_TIMEOUT, 0, cycles to wait for mem_resp before re-issuing the request; 0 disables the timeout.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- opcode  in  7  rv32i_opcode from IR
- funct3  in  3  from IR
- funct7  in  7  from IR
- br_en  in  1  CMP result
- mem_addr_lo  in  2  MAR[1:0], used for store byte enables
- mem_resp  in  1  memory done, single-cycle pulse
- mem_read, mem_write  out  1  memory request; held until mem_resp
- mem_byte_enable  out  4  write lane mask
- load_pc, load_ir, load_regfile, load_mar, load_mdr, load_data_out  out  1  datapath register loads
- pcmux_sel, alumux1_sel, marmux_sel, cmpmux_sel  out  1  mux selects
- alumux2_sel, alumux3_sel  out  2  mux selects
- regfilemux_sel  out  3  mux select
- aluop  out  alu_ops  ALU operation
- cmpop  out  branch_funct3_t  CMP operation
- ldop  out  load_funct3_t  load byte mask op; equals funct3

Behaviour:
- Mux encodings:
  - pcmux: 0 = pc+4, 1 = alu.
  - alumux1: 0 = rs1, 1 = pc.
  - alumux2: 0 = i, 1 = u, 2 = b, 3 = s.
  - alumux3: 0 = alumux2, 1 = rs2, 2 = j.
  - regfilemux: 0 = alu, 1 = br_en, 2 = u_imm, 3 = lbm, 4 = pc+4.
  - marmux: 0 = pc, 1 = alu.
  - cmpmux: 0 = rs2, 1 = i_imm.
- Defaults: every output 0 each cycle unless the state asserts it; aluop = add, cmpop = beq, mem_byte_enable = 4'hF.
- Reset: async to FETCH1 with all outputs at default. A reset mid-access drops mem_read/mem_write immediately. No register loads occur during reset.
- States and actions:
  - FETCH1: marmux = 0, load_mar. Next FETCH2.
  - FETCH2: mem_read, load_mdr. Stay until mem_resp, then FETCH3.
  - FETCH3: load_ir. Next DECODE.
  - DECODE: no loads. Dispatch on opcode.
  - IMM (op_imm):
    - slti/sltiu: cmpmux = 1, cmpop blt/bltu, regfilemux = 1.
    - srli/srai: srai selected when funct7[5] = 1.
    - All others: aluop from funct3.
    - Then load_regfile and load_pc (pc+4).
  - REG (op_reg):
    - alumux3 = 1.
    - add/sub: sub when funct7[5] = 1; same rule selects sra over srl.
    - slt/sltu use cmpmux = 0.
    - Then load_regfile and load_pc.
  - LUI: regfilemux = 2, load_regfile, load_pc.
  - AUIPC: alumux1 = 1, alumux2 = 1, add, load_regfile, load_pc.
  - BR: cmpop = funct3, alumux1 = 1, alumux2 = 2, add, load_pc. pcmux = br_en.
  - JAL: regfilemux = 4, load_regfile, alumux1 = 1, alumux3 = 2, pcmux = 1, load_pc.
  - JALR: regfilemux = 4, load_regfile, alumux1 = 0, alumux2 = 0, pcmux = 1, load_pc. The datapath clears bit 0.
  - CALC_LD: alumux2 = 0, add, marmux = 1, load_mar. Next LD1.
  - LD1: mem_read, load_mdr. Hold until mem_resp, then LD2.
  - LD2: regfilemux = 3, ldop = funct3, load_regfile, load_pc. Next FETCH1.
  - CALC_ST: alumux2 = 3, add, marmux = 1, load_mar, load_data_out. Next ST1.
  - ST1: mem_write with mem_byte_enable per store type:
    - sw: 4'hF.
    - sh: 4'h3 << mem_addr_lo.
    - sb: 4'h1 << mem_addr_lo.
    - Hold until mem_resp, then ST2.
  - ST2: load_pc. Next FETCH1.
  - All execute states except the CALC/LD/ST chain return to FETCH1.
- Illegal or unimplemented opcode: load_pc only (skip), then FETCH1. No regfile write.
- mem_resp outside FETCH2/LD1/ST1 is ignored.
- Timeout: when MEM_TIMEOUT > 0 and the wait counter reaches MEM_TIMEOUT, drop the request for one cycle, then re-assert it in the same state.
- Latency with single-cycle mem_resp:
  - ALU, LUI, branch and jump instructions: 5 cycles.
  - Loads: 7 cycles.
  - Stores: 7 cycles.

Optional Feature:
- CPU_CONTROL_PERF_EN defined: adds outputs perf_cycles[31:0] and perf_instret[31:0].
  - Both clear on reset.
  - perf_cycles increments every cycle.
  - perf_instret increments on each load_pc assertion.
  - Both wrap at 2^32.
- Undefined: ports and counters absent; behaviour otherwise identical.

Test Plan:
- Reset during FETCH2 with mem_read high -> mem_read = 0 while rst is high; after release, FETCH1 asserts load_mar with marmux = 0.
- addi x1,x0,5 with mem_resp one cycle after request -> load_regfile on cycle 5, aluop = add, regfilemux = 0, pcmux = 0.
- sub x3,x1,x2 (funct7 = 0x20) -> aluop = sub, alumux3_sel = 2'b01; sra with funct7 = 0x20 -> aluop = sra.
- beq with br_en = 1 -> pcmux_sel = 1 on the load_pc cycle; with br_en = 0 -> pcmux_sel = 0.
- sb with mem_addr_lo = 2 and mem_resp delayed 3 cycles -> mem_write held 4 cycles, mem_byte_enable = 4'b0100, then ST2 asserts load_pc.
- lh with mem_resp delayed 2 cycles -> LD2 asserts regfilemux = 3, ldop = lh, load_regfile. With CPU_CONTROL_PERF_EN, perf_instret increments by 1.
